// File: rtl/iterative_muldiv_alu_if.sv
// Issue/result bundle between the EX-stage control and the iterative mul/div ALU.
// The master launches operations and observes busy/done; the slave is the ALU.
interface iterative_muldiv_alu_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] read_data_1;
    logic [WIDTH-1:0] read_data_2;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_ctrl, read_data_1, read_data_2, shamt,
        input  alu_result, zero, hi, lo, busy, done
    );

    modport slave (
        input  start, alu_ctrl, read_data_1, read_data_2, shamt,
        output alu_result, zero, hi, lo, busy, done
    );
endinterface

// File: rtl/iterative_muldiv_alu.sv
// Clocked ALU: single-cycle logic/arith/shift ops plus WIDTH-cycle shift-add
// multiply and restoring divide, writing architectural HI/LO on completion.
module iterative_muldiv_alu #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    iterative_muldiv_alu_if.slave bus
);
    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = (SHW < 5) ? 5 : SHW;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] op_a_reg, op_a_next;
    logic [WIDTH-1:0] op_b_reg, op_b_next;
    // Shared iteration registers: product upper/lower half for MULTU,
    // partial remainder / dividend-becoming-quotient for DIVU.
    logic [WIDTH-1:0] work_hi_reg, work_hi_next;
    logic [WIDTH-1:0] work_lo_reg, work_lo_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;

    logic [WIDTH-1:0] single_result;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_step;
    logic [WIDTH-1:0] mul_lo_step;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] div_rem_step;
    logic [WIDTH-1:0] div_quo_step;

    // Single-cycle results straight from the sampled inputs; only used in IDLE.
    always_comb begin
        single_result = '0;
        case (bus.alu_ctrl)
            OP_AND:  single_result = bus.read_data_1 & bus.read_data_2;
            OP_OR:   single_result = bus.read_data_1 | bus.read_data_2;
            OP_ADD:  single_result = bus.read_data_1 + bus.read_data_2;
            OP_SUB:  single_result = bus.read_data_1 - bus.read_data_2;
            OP_SLTU: single_result = {{(WIDTH-1){1'b0}}, (bus.read_data_1 < bus.read_data_2)};
            OP_SLL:  single_result = bus.read_data_1 << bus.shamt;
            OP_SRL:  single_result = bus.read_data_1 >> bus.shamt;
            OP_NOT:  single_result = ~bus.read_data_1;
            OP_MFHI: single_result = hi_reg;
            OP_MFLO: single_result = lo_reg;
            default: single_result = '0;
        endcase
    end

    // One multiplier bit: conditionally add A into the upper half, then shift
    // the whole {carry, upper, lower} right by one.
    always_comb begin
        mul_sum     = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, op_a_reg} : {(WIDTH+1){1'b0}});
        mul_hi_step = mul_sum[WIDTH:1];
        mul_lo_step = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
    end

    // One restoring-divide step: the borrow bit of the trial subtraction
    // decides both the quotient bit and whether the remainder is restored.
    always_comb begin
        div_shift    = {work_hi_reg, work_lo_reg[WIDTH-1]};
        div_diff     = div_shift - {1'b0, op_b_reg};
        div_fits     = ~div_diff[WIDTH];
        div_rem_step = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_step = {work_lo_reg[WIDTH-2:0], div_fits};
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        op_a_next    = op_a_reg;
        op_b_next    = op_b_reg;
        work_hi_next = work_hi_reg;
        work_lo_next = work_lo_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        result_next  = result_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    op_a_next = bus.read_data_1;
                    op_b_next = bus.read_data_2;
                    cnt_next  = '0;
                    if (bus.alu_ctrl == OP_MULTU) begin
                        state_next   = ST_MUL;
                        work_hi_next = '0;
                        work_lo_next = bus.read_data_2;
                    end else if (bus.alu_ctrl == OP_DIVU) begin
                        if (bus.read_data_2 != '0) begin
                            state_next   = ST_DIV;
                            work_hi_next = '0;
                            work_lo_next = bus.read_data_1;
                        end else begin
                            // Divide by zero finishes immediately with a defined result.
                            state_next  = ST_DONE;
                            hi_next     = bus.read_data_1;
                            lo_next     = '1;
                            result_next = '1;
                        end
                    end else begin
                        state_next  = ST_DONE;
                        result_next = single_result;
                    end
                end
            end
            ST_MUL: begin
                work_hi_next = mul_hi_step;
                work_lo_next = mul_lo_step;
                cnt_next     = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_CNT) begin
                    state_next  = ST_DONE;
                    hi_next     = mul_hi_step;
                    lo_next     = mul_lo_step;
                    result_next = mul_lo_step;
                end
            end
            ST_DIV: begin
                work_hi_next = div_rem_step;
                work_lo_next = div_quo_step;
                cnt_next     = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_CNT) begin
                    state_next  = ST_DONE;
                    hi_next     = div_rem_step;
                    lo_next     = div_quo_step;
                    result_next = div_quo_step;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        zero_next = (result_next == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            work_hi_reg <= '0;
            work_lo_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            result_reg  <= '0;
            zero_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            op_a_reg    <= op_a_next;
            op_b_reg    <= op_b_next;
            work_hi_reg <= work_hi_next;
            work_lo_reg <= work_lo_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            result_reg  <= result_next;
            zero_reg    <= zero_next;
        end
    end

    assign bus.alu_result = result_reg;
    assign bus.zero       = zero_reg;
    assign bus.hi         = hi_reg;
    assign bus.lo         = lo_reg;
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.done       = (state_reg == ST_DONE);
endmodule

// File: tb/tb_iterative_muldiv_alu.sv
// Directed bench for iterative_muldiv_alu: an arithmetic reference model checked
// against the DUT every cycle, plus literal expectations per transaction.
module tb_iterative_muldiv_alu;
    localparam int W = 32;

    logic clk;
    logic rst;

    iterative_muldiv_alu_if #(.WIDTH(W)) bus ();

    iterative_muldiv_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural results from plain arithmetic, with
    // timing expressed as a countdown of cycles until the result appears.
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_hi     = '0;
    logic [W-1:0] m_lo     = '0;
    logic         m_busy   = 1'b0;
    logic         m_done   = 1'b0;
    int           m_left   = 0;
    logic [W-1:0] p_result, p_hi, p_lo;

    initial begin
        logic [2*W-1:0] prod;
        logic [W-1:0]   a, b;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_result = '0; m_hi = '0; m_lo = '0;
                m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_result = p_result; m_hi = p_hi; m_lo = p_lo;
                    m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end else if (bus.start) begin
                a = bus.read_data_1;
                b = bus.read_data_2;
                m_busy = 1'b1;
                m_done = 1'b1;
                case (bus.alu_ctrl)
                    4'b0000: m_result = a & b;
                    4'b0001: m_result = a | b;
                    4'b0010: m_result = a + b;
                    4'b0110: m_result = a - b;
                    4'b0111: m_result = (a < b) ? 32'd1 : 32'd0;
                    4'b0101: m_result = a << bus.shamt;
                    4'b1000: m_result = a >> bus.shamt;
                    4'b1001: m_result = ~a;
                    4'b1010: m_result = m_hi;
                    4'b1011: m_result = m_lo;
                    4'b1111: begin
                        prod     = {32'd0, a} * {32'd0, b};
                        p_hi     = prod[2*W-1:W];
                        p_lo     = prod[W-1:0];
                        p_result = p_lo;
                        m_done   = 1'b0;
                        m_left   = W;
                    end
                    4'b0011: begin
                        if (b == '0) begin
                            m_hi = a; m_lo = '1; m_result = '1;
                        end else begin
                            p_lo     = a / b;
                            p_hi     = a % b;
                            p_result = p_lo;
                            m_done   = 1'b0;
                            m_left   = W;
                        end
                    end
                    default: m_result = '0;
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("cyc_busy",   bus.busy,       m_busy);
            chk("cyc_done",   bus.done,       m_done);
            chk("cyc_result", bus.alu_result, m_result);
            chk("cyc_zero",   bus.zero,       (m_result == '0));
            chk("cyc_hi",     bus.hi,         m_hi);
            chk("cyc_lo",     bus.lo,         m_lo);
        end
    end

    task automatic do_op(input string name, input logic [3:0] ctrl,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sh, input int exp_lat,
                         input logic [W-1:0] e_res, input logic [W-1:0] e_hi,
                         input logic [W-1:0] e_lo, input int extra_at);
        int   lat;
        logic seen;
        @(negedge clk);
        bus.start = 1'b1; bus.alu_ctrl = ctrl;
        bus.read_data_1 = a; bus.read_data_2 = b; bus.shamt = sh;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // Operands change after launch; the latched values must be used.
                bus.start = 1'b0;
                bus.read_data_1 = ~a; bus.read_data_2 = a ^ b; bus.shamt = ~sh;
            end
            if (extra_at != 0 && lat == extra_at) begin
                bus.start = 1'b1; bus.alu_ctrl = 4'b0010;
            end
            if (extra_at != 0 && lat == extra_at + 1) bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_result"},  bus.alu_result, e_res);
        chk({name, "_zero"},    bus.zero, (e_res == '0));
        chk({name, "_hi"},      bus.hi, e_hi);
        chk({name, "_lo"},      bus.lo, e_lo);
        $display("op %-8s ctrl=%b a=%h b=%h sh=%0d -> result=%h hi=%h lo=%h zero=%b cycles=%0d",
                 name, ctrl, a, b, sh, bus.alu_result, bus.hi, bus.lo, bus.zero, lat);
        @(negedge clk);
        chk({name, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.alu_ctrl = '0;
        bus.read_data_1 = '0; bus.read_data_2 = '0; bus.shamt = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", bus.alu_result, 32'h0);
        chk("rst_zero",   bus.zero, 1'b1);
        chk("rst_busy",   bus.busy, 1'b0);
        chk("rst_done",   bus.done, 1'b0);
        chk("rst_hi",     bus.hi, 32'h0);
        chk("rst_lo",     bus.lo, 32'h0);
        #2 rst = 1'b0;

        do_op("and",   4'b0000, 32'h0000_00F0, 32'h0000_000F, 5'd0,  1, 32'h0,         32'h0, 32'h0, 0);
        do_op("or",    4'b0001, 32'h0000_00F0, 32'h0000_000F, 5'd0,  1, 32'hFF,        32'h0, 32'h0, 0);
        do_op("add",   4'b0010, 32'h0000_00F0, 32'h0000_000F, 5'd0,  1, 32'hFF,        32'h0, 32'h0, 0);
        do_op("sub",   4'b0110, 32'h0000_00F0, 32'h0000_000F, 5'd0,  1, 32'hE1,        32'h0, 32'h0, 0);
        do_op("sltu",  4'b0111, 32'hFFFF_FFFF, 32'h1,         5'd0,  1, 32'h0,         32'h0, 32'h0, 0);
        do_op("sltu1", 4'b0111, 32'h1,         32'hFFFF_FFFF, 5'd0,  1, 32'h1,         32'h0, 32'h0, 0);
        do_op("sll",   4'b0101, 32'h1,         32'h0,         5'd31, 1, 32'h8000_0000, 32'h0, 32'h0, 0);
        do_op("srl",   4'b1000, 32'h8000_0000, 32'h0,         5'd31, 1, 32'h1,         32'h0, 32'h0, 0);
        do_op("not",   4'b1001, 32'h0,         32'h0,         5'd0,  1, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);
        do_op("multu", 4'b1111, 32'h0001_0000, 32'h0001_0000, 5'd0, 33, 32'h0,         32'h1, 32'h0, 5);
        do_op("divu",  4'b0011, 32'd100,       32'd7,         5'd0, 33, 32'd14,        32'd2, 32'd14, 0);
        do_op("mfhi",  4'b1010, 32'h0,         32'h0,         5'd0,  1, 32'd2,         32'd2, 32'd14, 0);
        do_op("mflo",  4'b1011, 32'h0,         32'h0,         5'd0,  1, 32'd14,        32'd2, 32'd14, 0);
        do_op("div0",  4'b0011, 32'h1234,      32'h0,         5'd0,  1, 32'hFFFF_FFFF, 32'h1234, 32'hFFFF_FFFF, 0);
        do_op("undef", 4'b0100, 32'h5555_5555, 32'h1,         5'd0,  1, 32'h0,         32'h1234, 32'hFFFF_FFFF, 0);
        do_op("mulmax",4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 33, 32'h1,         32'hFFFF_FFFE, 32'h1, 0);
        do_op("divone",4'b0011, 32'hFFFF_FFFF, 32'h1,         5'd0, 33, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 0);

        // Reset in the middle of a multiply: everything clears, no late done.
        @(negedge clk);
        bus.start = 1'b1; bus.alu_ctrl = 4'b1111;
        bus.read_data_1 = 32'd5; bus.read_data_2 = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy",   bus.busy, 1'b0);
        chk("midrst_done",   bus.done, 1'b0);
        chk("midrst_hi",     bus.hi, 32'h0);
        chk("midrst_lo",     bus.lo, 32'h0);
        chk("midrst_result", bus.alu_result, 32'h0);
        chk("midrst_zero",   bus.zero, 1'b1);
        $display("op reset   mid-multiply -> busy=%b hi=%h lo=%h zero=%b",
                 bus.busy, bus.hi, bus.lo, bus.zero);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("no_late_done", bus.done, 1'b0);
        end
        do_op("add_post", 4'b0010, 32'd2, 32'd3, 5'd0, 1, 32'd5, 32'h0, 32'h0, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/iterative_muldiv_alu.md
# iterative_muldiv_alu

Parametrised, clocked successor to the single-cycle datapath ALU. It executes the same logic, arithmetic and shift operations in one cycle, and adds iterative unsigned multiply and divide over `WIDTH` cycles with architectural HI/LO registers. Every operation is launched with a start/busy/done handshake. It sits in the EX stage; the control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32: operand, result, HI and LO width in bits. Must be a power of two, ≥ 8.
- `SHW`, localparam `$clog2(WIDTH)`: shift-amount width.

- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  launches an operation; sampled only in IDLE.
- `alu_ctrl`  in  4  operation code, sampled with `start`.
- `read_data_1`  in  WIDTH  operand A, sampled with `start`.
- `read_data_2`  in  WIDTH  operand B, sampled with `start`.
- `shamt`  in  SHW  shift amount, sampled with `start`.
- `alu_result`  out  WIDTH  registered result.
- `zero`  out  1  registered; equals `alu_result == 0`.
- `hi`  out  WIDTH  HI register: product upper half, or remainder.
- `lo`  out  WIDTH  LO register: product lower half, or quotient.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `alu_result`, `hi` and `lo` are valid.

## Operation
- Opcodes; all arithmetic is unsigned and modulo 2^WIDTH:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLTU: result 1 if A<B, else 0.
  - 0101 SLL A by `shamt`; 1000 SRL A by `shamt`, zero fill.
  - 1001 NOT A.
  - 1010 MFHI: result = `hi`. 1011 MFLO: result = `lo`.
  - 1111 MULTU; 0011 DIVU.
  - Any other code: result 0.
- States:
  - IDLE: `start` with a single-cycle code → DONE; `alu_result` is loaded on the same edge.
  - IDLE: `start` with 1111 → MUL; 0011 with B≠0 → DIV; 0011 with B=0 → DONE.
  - MUL, DIV: 5-bit+ iteration counter runs from 0 to WIDTH-1. On the edge where the counter reaches WIDTH-1, the state moves to DONE and `hi`, `lo` and `alu_result` are written.
  - DONE: `done`=1 for exactly one cycle, then → IDLE unconditionally.
- Operands and the opcode are latched at start. Input changes while `busy` is high have no effect.
- `start` while `busy` is high is ignored; it is not queued.
- MULTU: shift-add, one partial-product bit per cycle. Result: {hi,lo} = A*B (2·WIDTH bits), `alu_result` = lo.
- DIVU: restoring, one quotient bit per cycle. Result: lo = A/B, hi = A%B, `alu_result` = lo.
- Divide by zero: completes in one cycle. lo = all ones, hi = A, `alu_result` = all ones.
- `hi` and `lo` change only on MULTU or DIVU completion. Single-cycle ops, including MFHI/MFLO, leave them unchanged.
- `alu_result` and `zero` hold their values until the next completion.
- Reset, asserted at any time including mid-iteration:
  - State → IDLE; the operation in flight is discarded.
  - `alu_result`=0, `hi`=0, `lo`=0, `busy`=0, `done`=0, `zero`=1.

## Timing
- Let N be the edge that samples `start` in IDLE.
- Single-cycle ops and divide-by-zero: `busy` and `done` are high from N to N+1. Back in IDLE at N+1.
- Next `start` is accepted at N+2 at the earliest. Throughput is one op per 2 cycles.
- MULTU/DIVU:
  - `busy` is high from N to N+WIDTH+1.
  - Iterations occur on edges N+1 … N+WIDTH.
  - `done` is high from N+WIDTH to N+WIDTH+1.
  - Results are visible from N+WIDTH.
- `done` never asserts without a preceding accepted `start`. `busy` is low again on the edge after `done`.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then AND/OR/ADD/SUB with A=0x0000_00F0, B=0x0000_000F (`start` 1 cycle each):
  - Results are 0x0, 0xFF, 0xFF and 0xE1.
  - `done` is high exactly 1 cycle after each start.
  - `zero`=1 only after the AND.
- SLTU with A=0xFFFF_FFFF, B=1 → result 0. SLL with A=1, `shamt`=31 → 0x8000_0000. SRL of that by 31 → 1. NOT 0 → 0xFFFF_FFFF.
- MULTU with A=0x0001_0000, B=0x0001_0000:
  - hi=1, lo=0, result=0, `zero`=1.
  - `done` high during cycle N+32 to N+33; `busy` high throughout.
  - A second `start` pulsed at N+5 is ignored.
- DIVU with A=100, B=7 → lo=14, hi=2, result=14, after 32 iterations. Then MFHI → 2, MFLO → 14, and hi/lo are unchanged.
- DIVU with A=0x1234, B=0 → `done` 1 cycle after start, result=0xFFFF_FFFF, hi=0x1234, lo=0xFFFF_FFFF.
- MULTU started, `reset` asserted mid-iteration (cycle 10) then released:
  - All outputs immediately take their reset values: hi=lo=0, `busy`=0, `zero`=1.
  - No `done` pulse follows.
  - A fresh ADD 2+3 → 5.
